dmem_arbiter: RTL

- Shares the single-port data memory between two requesters:
  - the pipeline's memory stage (core port);
  - an external loader/DMA port, used for program/data preload and result readback.
- Sits between processor_core and data_memory inside the top level.
- Core has fixed priority. A starvation counter guarantees the external port a slot; when that slot is forced, the core is stalled for one cycle.
- External reads return through a registered response path.

---
 rtl/dmem_arbiter.sv | 79 +++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core M stage (fixed priority)
// and an external loader/DMA port, with a starvation-forced slot and registered read return.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [31:0]      core_addr,
  input  logic [31:0]      core_wdata,
  output logic [31:0]      core_rdata,
  output logic             core_stall,
  input  logic             ext_req,
  input  logic             ext_we,
  input  logic [31:0]      ext_addr,
  input  logic [31:0]      ext_wdata,
  output logic             ext_ready,
  output logic             ext_rvalid,
  output logic [31:0]      ext_rdata,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd,
  output logic [CNT_W-1:0] core_cnt,
  output logic [CNT_W-1:0] ext_cnt
);

  localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

  logic [3:0]  wait_cnt;
  logic        starve;
  logic        grant_ext;
  logic        rvalid_p1;
  logic [31:0] rdata_p1;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= MAX_WAIT_L) ? MAX_WAIT_L : v + 4'd1;
  endfunction

  assign starve     = (wait_cnt == MAX_WAIT_L);
  assign grant_ext  = ext_req && (!core_req || starve);
  assign ext_ready  = grant_ext;
  assign core_stall = core_req && grant_ext;
  assign core_rdata = mem_rd;

  // Writes are suppressed for the whole reset window, whoever holds the port.
  assign mem_we   = !reset && (grant_ext ? ext_we : (core_req && core_we));
  assign mem_addr = grant_ext ? ext_addr  : core_addr;
  assign mem_wd   = grant_ext ? ext_wdata : core_wdata;

  assign ext_rvalid = rvalid_p1;
  assign ext_rdata  = rdata_p1;

  // p0 -> p1: wait counter, read response register, transaction counters
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= 4'd0;
      rvalid_p1 <= 1'b0;
      rdata_p1  <= 32'd0;
      core_cnt  <= '0;
      ext_cnt   <= '0;
    end else begin
      if (!ext_req || grant_ext)
        wait_cnt <= 4'd0;
      else
        wait_cnt <= sat_inc(wait_cnt);
      rvalid_p1 <= grant_ext && !ext_we;
      if (grant_ext && !ext_we)
        rdata_p1 <= mem_rd;
      if (core_req && !core_stall)
        core_cnt <= core_cnt + CNT_W'(1);
      if (grant_ext)
        ext_cnt <= ext_cnt + CNT_W'(1);
    end
  end

endmodule
